// File: rtl/systolic_seq_if.sv
// Job/config, stall and array-control signals of the systolic sequencer.
interface systolic_seq_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ROW_NUM    = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_len;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic                  hold;
  logic                  act_rd_en;
  logic [ADDR_WIDTH-1:0] act_rd_addr;
  logic [ROW_NUM-1:0]    arr_enable;
  logic                  arr_save;
  logic                  busy;
  logic                  done;
  logic                  err;

  // Job issuer / environment side
  modport master (
    output start, cfg_len, cfg_base, hold,
    input  act_rd_en, act_rd_addr, arr_enable, arr_save, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  start, cfg_len, cfg_base, hold,
    output act_rd_en, act_rd_addr, arr_enable, arr_save, busy, done, err
  );
endinterface

// File: rtl/systolic_seq.sv
// Sequencer streaming activation vectors into a skewed systolic array.
module systolic_seq #(
  parameter int unsigned PE_NUM     = 16,
  parameter int unsigned ROW_NUM    = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rstn,
  systolic_seq_if.slave bus
);

  localparam int unsigned DRAIN_CYC = ROW_NUM + PE_NUM - 1;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_DRAIN = 3'd2,
    S_SAVE  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DRAIN_W-1:0]    r_drain;
  logic [ROW_NUM-1:0]    r_skew;
  logic                  r_zero;

  logic                  w_accept;
  logic                  w_zero_req;
  logic                  w_issue;
  logic                  w_last;
  logic                  w_drain_end;
  logic [ROW_NUM-1:0]    w_skew_nxt;

  // Decode of the current cycle's events
  always_comb begin
    w_accept    = 1'b0;
    w_zero_req  = 1'b0;
    w_issue     = 1'b0;
    w_last      = 1'b0;
    w_drain_end = 1'b0;
    w_skew_nxt  = r_skew;
    if (r_state == S_IDLE && bus.start) begin
      w_accept   = (bus.cfg_len != '0);
      w_zero_req = (bus.cfg_len == '0);
    end
    w_issue     = (r_state == S_FILL) && !bus.hold;
    w_last      = (r_idx == r_len - ADDR_WIDTH'(1));
    w_drain_end = (r_drain == DRAIN_W'(DRAIN_CYC - 1));
    w_skew_nxt  = (r_skew << 1) | ROW_NUM'(w_issue);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state; hold stalls FILL/DRAIN only, SAVE and DONE always advance
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FILL;
      S_FILL:  if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!bus.hold && w_drain_end) w_next = S_SAVE;
      S_SAVE:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job config, read index and drain counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len   <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_drain <= '0;
    end else begin
      if (w_accept) begin
        r_len  <= bus.cfg_len;
        r_base <= bus.cfg_base;
        r_idx  <= '0;
      end else if (w_issue) begin
        r_idx <= r_idx + ADDR_WIDTH'(1);
      end
      if (w_issue && w_last) begin
        r_drain <= '0;
      end else if (r_state == S_DRAIN && !bus.hold) begin
        r_drain <= r_drain + DRAIN_W'(1);
      end
    end
  end

  // Diagonal enable skew: row r sees the read strobe r+1 unstalled cycles later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_skew <= '0;
    else if (!bus.hold) r_skew <= w_skew_nxt;
  end

  // Zero-length request reports err/done one cycle after the start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_zero <= 1'b0;
    else       r_zero <= w_zero_req;
  end

  // Outputs decoded from registered state; hold masks the read strobe and enables
  always_comb begin
    bus.act_rd_en   = 1'b0;
    bus.act_rd_addr = '0;
    bus.arr_enable  = '0;
    bus.arr_save    = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    if (w_issue) begin
      bus.act_rd_en   = 1'b1;
      bus.act_rd_addr = r_base + r_idx;
    end
    if (!bus.hold) bus.arr_enable = r_skew;
    bus.arr_save = (r_state == S_SAVE);
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_DONE) || r_zero;
    bus.err      = r_zero;
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq against a job-level reference model.
module tb_systolic_seq;
  localparam int unsigned PE   = 4;
  localparam int unsigned ROW  = 4;
  localparam int unsigned AW   = 10;
  localparam int          MAXC = 1200;
  localparam int          DR   = int'(ROW + PE - 1);

  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_seq_if #(.ADDR_WIDTH(AW), .ROW_NUM(ROW)) bus ();

  systolic_seq #(.PE_NUM(PE), .ROW_NUM(ROW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Per-cycle stimulus
  bit s_start [MAXC];
  int s_len   [MAXC];
  int s_base  [MAXC];
  bit s_hold  [MAXC];
  // Expected outputs
  bit e_rd   [MAXC];
  int e_addr [MAXC];
  int e_en   [MAXC];
  bit e_save [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_err  [MAXC];
  // Observed outputs
  logic          o_rd   [MAXC];
  logic [AW-1:0] o_addr [MAXC];
  logic [ROW-1:0] o_en  [MAXC];
  logic          o_save [MAXC];
  logic          o_busy [MAXC];
  logic          o_done [MAXC];
  logic          o_err  [MAXC];

  int checks  = 0;
  int errors  = 0;
  int cur_cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start    = 1'b0;
    bus.cfg_len  = '0;
    bus.cfg_base = '0;
    bus.hold     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd"},   64'(bus.act_rd_en),   64'(0));
    check_val({tag, "_addr"}, 64'(bus.act_rd_addr), 64'(0));
    check_val({tag, "_en"},   64'(bus.arr_enable),  64'(0));
    check_val({tag, "_save"}, 64'(bus.arr_save),    64'(0));
    check_val({tag, "_busy"}, 64'(bus.busy),        64'(0));
    check_val({tag, "_done"}, 64'(bus.done),        64'(0));
    check_val({tag, "_err"},  64'(bus.err),         64'(0));
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_cyc = -1;
    check_all_zero("rst");
    rstn = 1'b1;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      s_start[c] = 1'b0;
      s_len[c]   = 0;
      s_base[c]  = 0;
      s_hold[c]  = 1'b0;
    end
  endtask

  task automatic add_job(input int c, input int len, input int base);
    s_start[c] = 1'b1;
    s_len[c]   = len;
    s_base[c]  = base;
  endtask

  // Job-level model: a job reads len vectors on unstalled cycles, drains for
  // ROW+PE-1 unstalled cycles, then one save cycle and one done cycle.
  task automatic build_expected(input int n);
    int  phase = 0;
    int  idx   = 0;
    int  len   = 0;
    int  base  = 0;
    int  dcnt  = 0;
    bit  zpend = 1'b0;
    for (int c = 0; c < n; c++) begin
      e_rd[c]   = (phase == 1) && !s_hold[c];
      e_addr[c] = e_rd[c] ? (base + idx) % (1 << AW) : 0;
      e_save[c] = (phase == 3);
      e_busy[c] = (phase != 0);
      e_done[c] = (phase == 4) || zpend;
      e_err[c]  = zpend;
      zpend = (phase == 0) && s_start[c] && (s_len[c] == 0);
      case (phase)
        0: if (s_start[c] && s_len[c] != 0) begin
             phase = 1; len = s_len[c]; base = s_base[c]; idx = 0;
           end
        1: if (!s_hold[c]) begin
             idx++;
             if (idx == len) begin phase = 2; dcnt = 0; end
           end
        2: if (!s_hold[c]) begin
             dcnt++;
             if (dcnt == DR) phase = 3;
           end
        3: phase = 4;
        default: phase = 0;
      endcase
    end
    // Row r echoes the read strobe of the (r+1)-th previous unstalled cycle
    for (int c = 0; c < n; c++) begin
      int k;
      e_en[c] = 0;
      k = 0;
      if (!s_hold[c]) begin
        for (int m = c - 1; m >= 0; m--) begin
          if (k >= int'(ROW)) break;
          if (!s_hold[m]) begin
            if (e_rd[m]) e_en[c] = e_en[c] | (1 << k);
            k++;
          end
        end
      end
    end
  endtask

  task automatic run_seg(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      bus.start    = s_start[c];
      bus.cfg_len  = AW'(s_len[c]);
      bus.cfg_base = AW'(s_base[c]);
      bus.hold     = s_hold[c];
      @(negedge clk);
      cur_cyc   = c;
      o_rd[c]   = bus.act_rd_en;
      o_addr[c] = bus.act_rd_addr;
      o_en[c]   = bus.arr_enable;
      o_save[c] = bus.arr_save;
      o_busy[c] = bus.busy;
      o_done[c] = bus.done;
      o_err[c]  = bus.err;
      check_val("rd_en",  64'(o_rd[c]),   64'(e_rd[c]));
      check_val("addr",   64'(o_addr[c]), 64'(e_addr[c]));
      check_val("enable", 64'(o_en[c]),   64'(e_en[c]));
      check_val("save",   64'(o_save[c]), 64'(e_save[c]));
      check_val("busy",   64'(o_busy[c]), 64'(e_busy[c]));
      check_val("done",   64'(o_done[c]), 64'(e_done[c]));
      check_val("err",    64'(o_err[c]),  64'(e_err[c]));
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  initial begin
    int cnt;
    rstn = 1'b0;
    drive_idle();

    // Nominal job: base 5, len 3
    clear_stim(); add_job(0, 3, 5); build_expected(16);
    apply_reset(); run_seg(16);
    cur_cyc = -2;
    check_val("t1_rd0",   64'(o_rd[0]),   64'(0));
    check_val("t1_a1",    64'(o_addr[1]), 64'(5));
    check_val("t1_a2",    64'(o_addr[2]), 64'(6));
    check_val("t1_a3",    64'(o_addr[3]), 64'(7));
    check_val("t1_e0c2",  64'(o_en[2][0]), 64'(1));
    check_val("t1_e0c4",  64'(o_en[4][0]), 64'(1));
    check_val("t1_e0c5",  64'(o_en[5][0]), 64'(0));
    check_val("t1_e3c5",  64'(o_en[5][3]), 64'(1));
    check_val("t1_e3c7",  64'(o_en[7][3]), 64'(1));
    check_val("t1_e3c8",  64'(o_en[8][3]), 64'(0));
    check_val("t1_save11", 64'(o_save[11]), 64'(1));
    check_val("t1_done11", 64'(o_done[11]), 64'(0));
    check_val("t1_done12", 64'(o_done[12]), 64'(1));

    // Address wrap at the top of the buffer
    clear_stim(); add_job(0, 4, (1 << AW) - 2); build_expected(20);
    apply_reset(); run_seg(20);
    cur_cyc = -2;
    check_val("t2_a1", 64'(o_addr[1]), 64'((1 << AW) - 2));
    check_val("t2_a2", 64'(o_addr[2]), 64'((1 << AW) - 1));
    check_val("t2_a3", 64'(o_addr[3]), 64'(0));
    check_val("t2_a4", 64'(o_addr[4]), 64'(1));

    // Three stall cycles mid-FILL
    clear_stim(); add_job(0, 3, 5);
    s_hold[2] = 1'b1; s_hold[3] = 1'b1; s_hold[4] = 1'b1;
    build_expected(20);
    apply_reset(); run_seg(20);
    cur_cyc = -2;
    check_val("t3_rd3",   64'(o_rd[3]),    64'(0));
    check_val("t3_a5",    64'(o_addr[5]),  64'(6));
    check_val("t3_a6",    64'(o_addr[6]),  64'(7));
    check_val("t3_done12", 64'(o_done[12]), 64'(0));
    check_val("t3_done15", 64'(o_done[15]), 64'(1));

    // Zero-length request
    clear_stim(); add_job(0, 0, 9); build_expected(6);
    apply_reset(); run_seg(6);
    cur_cyc = -2;
    check_val("t4_err1",  64'(o_err[1]),  64'(1));
    check_val("t4_done1", 64'(o_done[1]), 64'(1));
    cnt = 0;
    for (int c = 0; c < 6; c++) cnt += int'(o_busy[c]) + int'(o_rd[c]);
    check_val("t4_busy_rd", 64'(cnt), 64'(0));

    // Hold during SAVE and DONE does not delay them
    clear_stim(); add_job(0, 1, 3); s_hold[9] = 1'b1; s_hold[10] = 1'b1;
    build_expected(14);
    apply_reset(); run_seg(14);
    cur_cyc = -2;
    check_val("t5_save9",  64'(o_save[9]),  64'(1));
    check_val("t5_done10", 64'(o_done[10]), 64'(1));

    // Start held high: one job per IDLE acceptance
    clear_stim();
    for (int c = 0; c <= 30; c++) add_job(c, 2, 100);
    build_expected(40);
    apply_reset(); run_seg(40);
    cur_cyc = -2;
    check_val("t6_done11", 64'(o_done[11]), 64'(1));
    check_val("t6_rd12",   64'(o_rd[12]),   64'(0));
    check_val("t6_rd13",   64'(o_rd[13]),   64'(1));
    check_val("t6_a13",    64'(o_addr[13]), 64'(100));
    cnt = 0;
    for (int c = 0; c < 40; c++) cnt += int'(o_done[c]);
    check_val("t6_jobs", 64'(cnt), 64'(3));

    // Reset during DRAIN aborts; next job has nominal timing
    clear_stim(); add_job(0, 3, 5); build_expected(6);
    apply_reset(); run_seg(6);
    #1 rstn = 1'b0;
    #1 cur_cyc = -3;
    check_all_zero("abort");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("abort2");
    rstn = 1'b1;
    clear_stim(); add_job(0, 3, 5); build_expected(16);
    run_seg(16);
    cur_cyc = -2;
    check_val("t7_done12", 64'(o_done[12]), 64'(1));

    // Maximum length streams every vector
    clear_stim(); add_job(0, (1 << AW) - 1, 7); build_expected(1040);
    apply_reset(); run_seg(1040);
    cur_cyc = -2;
    check_val("t8_alast",  64'(o_addr[1023]), 64'((7 + 1022) % (1 << AW)));
    check_val("t8_done",   64'(o_done[1032]), 64'(1));

    // Randomized jobs, stalls and stray starts
    for (int seg = 0; seg < 6; seg++) begin
      clear_stim();
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 7) == 0)
          add_job(c, int'($urandom_range(0, 6)), int'($urandom_range(0, (1 << AW) - 1)));
        s_hold[c] = ($urandom_range(0, 3) == 0);
      end
      build_expected(200);
      apply_reset(); run_seg(200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 SHALL have parameter PE_NUM, default 16, meaning PEs per systolic row (columns).
REQ-002 SHALL have parameter ROW_NUM, default 16, meaning systolic rows driven.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, meaning activation-buffer address and length width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning job request, sampled only in IDLE.
REQ-007 SHALL have port cfg_len, input, ADDR_WIDTH, meaning number of activation vectors, captured on accepted start.
REQ-008 SHALL have port cfg_base, input, ADDR_WIDTH, meaning first buffer address, captured on accepted start.
REQ-009 SHALL have port hold, input, 1, meaning stall request from the activation buffer or downstream.
REQ-010 SHALL have port act_rd_en, output, 1, meaning activation-buffer read strobe; read data returns one cycle later.
REQ-011 SHALL have port act_rd_addr, output, ADDR_WIDTH, meaning activation-buffer read address.
REQ-012 SHALL have port arr_enable, output, ROW_NUM, meaning per-row enable into each systolic row's first PE.
REQ-013 SHALL have port arr_save, output, 1, meaning broadcast save pulse to all PEs.
REQ-014 SHALL have port busy, output, 1, meaning job in progress (state not IDLE).
REQ-015 SHALL have port done, output, 1, meaning one-cycle job-complete pulse.
REQ-016 SHALL have port err, output, 1, meaning one-cycle pulse on start with cfg_len==0.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, DRAIN, SAVE, DONE.
REQ-018 IDLE: start=1 with cfg_len!=0 SHALL latch cfg_len/cfg_base and go to FILL next cycle; start with cfg_len==0 SHALL pulse err and done one cycle later and stay IDLE.
REQ-019 FILL: each non-hold cycle SHALL assert act_rd_en with act_rd_addr = base + index, index 0..len-1; address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-020 FILL SHALL go to DRAIN the cycle after issuing index len-1.
REQ-021 arr_enable[0] SHALL equal act_rd_en delayed one cycle; arr_enable[r] SHALL equal arr_enable[r-1] delayed one cycle (diagonal skew).
REQ-022 DRAIN SHALL last exactly ROW_NUM+PE_NUM-1 non-hold cycles counted from entry, then go to SAVE.
REQ-023 SAVE SHALL assert arr_save for exactly one cycle, then go to DONE.
REQ-024 DONE SHALL assert done for one cycle, then go to IDLE; start is ignored in every state except IDLE.
REQ-025 hold=1 SHALL freeze the FSM, all counters and the enable skew chain, and force act_rd_en=0; arr_enable SHALL be 0 while hold=1 and SHALL resume its frozen pattern after release.
REQ-026 hold SHALL NOT delay the arr_save pulse once in SAVE, nor done once in DONE.
REQ-027 busy SHALL be 1 in FILL, DRAIN, SAVE and DONE, and 0 in IDLE.
REQ-028 The length counter SHALL be ADDR_WIDTH bits; cfg_len = 2^ADDR_WIDTH-1 SHALL stream all vectors with no overflow.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE and set act_rd_en, act_rd_addr, arr_enable, arr_save, busy, done and err to 0, and clear all counters and the skew chain.
REQ-030 Reset asserted mid-job SHALL abort the job with no done or save pulse; the first start after release SHALL be accepted normally.

Verification
REQ-031 SHALL cover: PE_NUM=ROW_NUM=4, base=5, len=3, start -> addrs 5,6,7 on cycles 1..3; arr_enable[0] cycles 2..4, [3] cycles 5..7; arr_save at cycle 11; done at cycle 12.
REQ-032 SHALL cover: base=2^ADDR_WIDTH-2, len=4 -> addrs wrap to ..FE, ..FF, 0, 1.
REQ-033 SHALL cover: hold=1 for 3 cycles mid-FILL -> no reads during hold, address sequence contiguous, done delayed by exactly 3 cycles.
REQ-034 SHALL cover: start with len=0 -> err and done pulse, busy stays 0, no act_rd_en.
REQ-035 SHALL cover: rstn low during DRAIN -> all outputs 0 immediately, no done; new job then completes with nominal timing.
REQ-036 SHALL cover: start held high through DONE -> exactly one job per IDLE acceptance, with the next job starting the cycle after returning to IDLE.
